// File: rtl/wb_pkg.sv
// Shared definitions for the MEM/WB latch and writeback stage: default widths
// and the source-select encodings for the RF, HI and LO write muxes.
package wb_pkg;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_AW = 5;

  typedef enum logic [2:0] {
    RF_SEL_ALU    = 3'd0,
    RF_SEL_DMEM   = 3'd1,
    RF_SEL_PC4    = 3'd2,
    RF_SEL_CLZ    = 3'd3,
    RF_SEL_HI     = 3'd4,
    RF_SEL_LO     = 3'd5,
    RF_SEL_MUL_LO = 3'd6,
    RF_SEL_CP0    = 3'd7
  } rf_sel_e;

  typedef enum logic [1:0] {
    HI_SEL_RS   = 2'd0,
    HI_SEL_MUL  = 2'd1,
    HI_SEL_DIV  = 2'd2,
    HI_SEL_NONE = 2'd3
  } hi_sel_e;

  typedef enum logic [1:0] {
    LO_SEL_RS   = 2'd0,
    LO_SEL_MUL  = 2'd1,
    LO_SEL_DIV  = 2'd2,
    LO_SEL_NONE = 2'd3
  } lo_sel_e;

  // A HI/LO write is pending when a real instruction requests it with a real source.
  function automatic logic hilo_pending(input logic valid, input logic wena,
                                        input logic [1:0] sel);
    return valid & wena & (sel != 2'(HI_SEL_NONE));
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage to writeback-stage bus, plus the writeback outputs to RF and EX.
interface wb_stage_if #(
  parameter int unsigned DW = wb_pkg::WB_DW,
  parameter int unsigned AW = wb_pkg::WB_AW
) ();

  logic          wb_stall;
  logic          wb_flush;
  logic [DW-1:0] mem_mul_hi, mem_mul_lo, mem_div_r, mem_div_q;
  logic [DW-1:0] mem_clz_out, mem_alu_out, mem_dmem_out, mem_pc4;
  logic [DW-1:0] mem_rs_data_out, mem_cp0_out, mem_hi_out, mem_lo_out;
  logic [AW-1:0] mem_rf_waddr;
  logic          mem_rf_wena, mem_hi_wena, mem_lo_wena;
  logic [1:0]    mem_hi_mux_sel, mem_lo_mux_sel;
  logic [2:0]    mem_rf_mux_sel;
  logic [AW-1:0] wb_rf_waddr;
  logic [DW-1:0] wb_rf_wdata;
  logic          wb_rf_wena;
  logic [DW-1:0] hi_q, lo_q;
  logic          wb_valid;

  modport master (
    output wb_stall, wb_flush,
    output mem_mul_hi, mem_mul_lo, mem_div_r, mem_div_q,
    output mem_clz_out, mem_alu_out, mem_dmem_out, mem_pc4,
    output mem_rs_data_out, mem_cp0_out, mem_hi_out, mem_lo_out,
    output mem_rf_waddr, mem_rf_wena, mem_hi_wena, mem_lo_wena,
    output mem_hi_mux_sel, mem_lo_mux_sel, mem_rf_mux_sel,
    input  wb_rf_waddr, wb_rf_wdata, wb_rf_wena, hi_q, lo_q, wb_valid
  );

  modport slave (
    input  wb_stall, wb_flush,
    input  mem_mul_hi, mem_mul_lo, mem_div_r, mem_div_q,
    input  mem_clz_out, mem_alu_out, mem_dmem_out, mem_pc4,
    input  mem_rs_data_out, mem_cp0_out, mem_hi_out, mem_lo_out,
    input  mem_rf_waddr, mem_rf_wena, mem_hi_wena, mem_lo_wena,
    input  mem_hi_mux_sel, mem_lo_mux_sel, mem_rf_mux_sel,
    output wb_rf_waddr, wb_rf_wdata, wb_rf_wena, hi_q, lo_q, wb_valid
  );

endinterface

// File: rtl/wb_hilo_regs.sv
// Architectural HI/LO registers with their write-source muxes and the bypass
// that lets EX see a write still sitting in the writeback latch.
module wb_hilo_regs
  import wb_pkg::*;
#(
  parameter int unsigned   DW       = WB_DW,
  parameter logic [DW-1:0] HILO_RST = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_stall,
  input  logic          i_valid,
  input  logic          i_hi_wena,
  input  logic          i_lo_wena,
  input  logic [1:0]    i_hi_sel,
  input  logic [1:0]    i_lo_sel,
  input  logic [DW-1:0] i_rs_data,
  input  logic [DW-1:0] i_mul_hi,
  input  logic [DW-1:0] i_mul_lo,
  input  logic [DW-1:0] i_div_r,
  input  logic [DW-1:0] i_div_q,
  output logic [DW-1:0] o_hi_q_c,
  output logic [DW-1:0] o_lo_q_c
);

  logic [DW-1:0] r_hi, r_lo;
  logic [DW-1:0] w_hi_wdata, w_lo_wdata;
  logic          w_hi_pend, w_lo_pend;

  always_comb begin
    w_hi_wdata = i_rs_data;
    case (i_hi_sel)
      HI_SEL_MUL: w_hi_wdata = i_mul_hi;
      HI_SEL_DIV: w_hi_wdata = i_div_r;
      default:    w_hi_wdata = i_rs_data;
    endcase
  end

  always_comb begin
    w_lo_wdata = i_rs_data;
    case (i_lo_sel)
      LO_SEL_MUL: w_lo_wdata = i_mul_lo;
      LO_SEL_DIV: w_lo_wdata = i_div_q;
      default:    w_lo_wdata = i_rs_data;
    endcase
  end

  assign w_hi_pend = hilo_pending(i_valid, i_hi_wena, i_hi_sel);
  assign w_lo_pend = hilo_pending(i_valid, i_lo_wena, i_lo_sel);

  // A stalled writer commits once, on the edge it finally leaves the latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= HILO_RST;
      r_lo <= HILO_RST;
    end else if (!i_stall) begin
      if (w_hi_pend) r_hi <= w_hi_wdata;
      if (w_lo_pend) r_lo <= w_lo_wdata;
    end
  end

  assign o_hi_q_c = w_hi_pend ? w_hi_wdata : r_hi;
  assign o_lo_q_c = w_lo_pend ? w_lo_wdata : r_lo;

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline latch and writeback stage: selects the RF write-back value
// and hosts the HI/LO register block.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned   DW       = WB_DW,
  parameter int unsigned   AW       = WB_AW,
  parameter logic [DW-1:0] HILO_RST = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  wb_stage_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] mul_hi, mul_lo, div_r, div_q;
    logic [DW-1:0] clz_out, alu_out, dmem_out, pc4;
    logic [DW-1:0] rs_data, cp0_out, hi_out, lo_out;
    logic [AW-1:0] rf_waddr;
    logic          rf_wena, hi_wena, lo_wena;
    logic [1:0]    hi_sel, lo_sel;
    logic [2:0]    rf_sel;
  } lat_t;

  lat_t          r_lat, w_cap;
  logic [DW-1:0] w_rf_wdata;

  always_comb begin
    w_cap          = '0;
    w_cap.valid    = 1'b1;
    w_cap.mul_hi   = bus.mem_mul_hi;
    w_cap.mul_lo   = bus.mem_mul_lo;
    w_cap.div_r    = bus.mem_div_r;
    w_cap.div_q    = bus.mem_div_q;
    w_cap.clz_out  = bus.mem_clz_out;
    w_cap.alu_out  = bus.mem_alu_out;
    w_cap.dmem_out = bus.mem_dmem_out;
    w_cap.pc4      = bus.mem_pc4;
    w_cap.rs_data  = bus.mem_rs_data_out;
    w_cap.cp0_out  = bus.mem_cp0_out;
    w_cap.hi_out   = bus.mem_hi_out;
    w_cap.lo_out   = bus.mem_lo_out;
    w_cap.rf_waddr = bus.mem_rf_waddr;
    w_cap.rf_wena  = bus.mem_rf_wena;
    w_cap.hi_wena  = bus.mem_hi_wena;
    w_cap.lo_wena  = bus.mem_lo_wena;
    w_cap.hi_sel   = bus.mem_hi_mux_sel;
    w_cap.lo_sel   = bus.mem_lo_mux_sel;
    w_cap.rf_sel   = bus.mem_rf_mux_sel;
  end

  // Flush beats stall; a bubble is all-zero so no enable can leak through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat <= '0;
    end else if (bus.wb_flush) begin
      r_lat <= '0;
    end else if (!bus.wb_stall) begin
      r_lat <= w_cap;
    end
  end

  always_comb begin
    w_rf_wdata = r_lat.alu_out;
    case (r_lat.rf_sel)
      RF_SEL_ALU:    w_rf_wdata = r_lat.alu_out;
      RF_SEL_DMEM:   w_rf_wdata = r_lat.dmem_out;
      RF_SEL_PC4:    w_rf_wdata = r_lat.pc4;
      RF_SEL_CLZ:    w_rf_wdata = r_lat.clz_out;
      RF_SEL_HI:     w_rf_wdata = r_lat.hi_out;
      RF_SEL_LO:     w_rf_wdata = r_lat.lo_out;
      RF_SEL_MUL_LO: w_rf_wdata = r_lat.mul_lo;
      RF_SEL_CP0:    w_rf_wdata = r_lat.cp0_out;
      default:       w_rf_wdata = r_lat.alu_out;
    endcase
  end

  assign bus.wb_rf_wdata = w_rf_wdata;
  assign bus.wb_rf_waddr = r_lat.rf_waddr;
  assign bus.wb_rf_wena  = r_lat.rf_wena & r_lat.valid & (r_lat.rf_waddr != '0);
  assign bus.wb_valid    = r_lat.valid;

  wb_hilo_regs #(
    .DW       (DW),
    .HILO_RST (HILO_RST)
  ) u_hilo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_stall   (bus.wb_stall),
    .i_valid   (r_lat.valid),
    .i_hi_wena (r_lat.hi_wena),
    .i_lo_wena (r_lat.lo_wena),
    .i_hi_sel  (r_lat.hi_sel),
    .i_lo_sel  (r_lat.lo_sel),
    .i_rs_data (r_lat.rs_data),
    .i_mul_hi  (r_lat.mul_hi),
    .i_mul_lo  (r_lat.mul_lo),
    .i_div_r   (r_lat.div_r),
    .i_div_q   (r_lat.div_q),
    .o_hi_q_c  (bus.hi_q),
    .o_lo_q_c  (bus.lo_q)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic, checked against
// an instruction-level model of the writeback latch and HI/LO state.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if bus ();

  wb_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // d[] slots: 0 mul_hi 1 mul_lo 2 div_r 3 div_q 4 clz 5 alu 6 dmem 7 pc4
  //            8 rs 9 cp0 10 hi_out 11 lo_out
  typedef struct packed {
    logic              valid;
    logic [11:0][31:0] d;
    logic [4:0]        waddr;
    logic              rf_wena, hi_wena, lo_wena;
    logic [1:0]        hi_sel, lo_sel;
    logic [2:0]        rf_sel;
  } txn_t;

  localparam int RF_IDX [8] = '{5, 6, 7, 4, 10, 11, 1, 9};
  localparam int HI_IDX [3] = '{8, 0, 2};
  localparam int LO_IDX [3] = '{8, 1, 3};

  txn_t        m_lat;
  logic [31:0] m_hi, m_lo;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic hi_pend(input txn_t t);
    return t.valid && t.hi_wena && (t.hi_sel != 2'd3);
  endfunction

  function automatic logic lo_pend(input txn_t t);
    return t.valid && t.lo_wena && (t.lo_sel != 2'd3);
  endfunction

  function automatic logic [31:0] exp_hi();
    if (hi_pend(m_lat)) return m_lat.d[HI_IDX[int'(m_lat.hi_sel)]];
    return m_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
    if (lo_pend(m_lat)) return m_lat.d[LO_IDX[int'(m_lat.lo_sel)]];
    return m_lo;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(bus.wb_valid), 32'(m_lat.valid));
    chk({tag, ".wena"},  32'(bus.wb_rf_wena),
        32'(m_lat.valid && m_lat.rf_wena && (m_lat.waddr != 5'd0)));
    chk({tag, ".waddr"}, 32'(bus.wb_rf_waddr), 32'(m_lat.waddr));
    chk({tag, ".wdata"}, bus.wb_rf_wdata, m_lat.d[RF_IDX[int'(m_lat.rf_sel)]]);
    chk({tag, ".hi_q"},  bus.hi_q, exp_hi());
    chk({tag, ".lo_q"},  bus.lo_q, exp_lo());
  endtask

  task automatic drive(input txn_t t);
    bus.mem_mul_hi      = t.d[0];
    bus.mem_mul_lo      = t.d[1];
    bus.mem_div_r       = t.d[2];
    bus.mem_div_q       = t.d[3];
    bus.mem_clz_out     = t.d[4];
    bus.mem_alu_out     = t.d[5];
    bus.mem_dmem_out    = t.d[6];
    bus.mem_pc4         = t.d[7];
    bus.mem_rs_data_out = t.d[8];
    bus.mem_cp0_out     = t.d[9];
    bus.mem_hi_out      = t.d[10];
    bus.mem_lo_out      = t.d[11];
    bus.mem_rf_waddr    = t.waddr;
    bus.mem_rf_wena     = t.rf_wena;
    bus.mem_hi_wena     = t.hi_wena;
    bus.mem_lo_wena     = t.lo_wena;
    bus.mem_hi_mux_sel  = t.hi_sel;
    bus.mem_lo_mux_sel  = t.lo_sel;
    bus.mem_rf_mux_sel  = t.rf_sel;
  endtask

  function automatic txn_t rand_txn();
    txn_t t = '0;
    for (int i = 0; i < 12; i++) t.d[i] = $urandom;
    t.waddr   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    t.rf_wena = 1'($urandom);
    t.hi_wena = 1'($urandom);
    t.lo_wena = 1'($urandom);
    t.hi_sel  = 2'($urandom);
    t.lo_sel  = 2'($urandom);
    t.rf_sel  = 3'($urandom);
    return t;
  endfunction

  // Present one instruction for one edge, advance the model, check at the next negedge.
  task automatic step(input logic stall, input logic flush, input txn_t t, input string tag);
    logic [31:0] nh, nl;
    drive(t);
    bus.wb_stall = stall;
    bus.wb_flush = flush;
    @(posedge clk);
    nh = exp_hi();
    nl = exp_lo();
    if (!stall) begin
      m_hi = nh;
      m_lo = nl;
    end
    if (flush) m_lat = '0;
    else if (!stall) begin
      m_lat       = t;
      m_lat.valid = 1'b1;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  txn_t t;
  txn_t mthi;

  initial begin
    m_lat = '0;
    m_hi  = '0;
    m_lo  = '0;
    drive('0);
    bus.wb_stall = 1'b0;
    bus.wb_flush = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");

    // RF source sweep: alu=0x11 .. cp0=0x88 in select order
    t = '0;
    t.d[5] = 32'h11; t.d[6] = 32'h22; t.d[7]  = 32'h33; t.d[4]  = 32'h44;
    t.d[10] = 32'h55; t.d[11] = 32'h66; t.d[1] = 32'h77; t.d[9] = 32'h88;
    t.waddr = 5'd5;
    t.rf_wena = 1'b1;
    for (int s = 0; s < 8; s++) begin
      t.rf_sel = 3'(s);
      step(1'b0, 1'b0, t, "rf_sweep");
      chk("rf_sweep_const", bus.wb_rf_wdata, 32'(32'h11 * (s + 1)));
    end

    // register-0 write suppression
    t.waddr = 5'd0;
    step(1'b0, 1'b0, t, "r0");
    chk("r0_wena", 32'(bus.wb_rf_wena), 32'd0);
    t.waddr = 5'd31;
    step(1'b0, 1'b0, t, "r31");
    chk("r31_wena", 32'(bus.wb_rf_wena), 32'd1);

    // mult writes HI and LO together; bypass then register
    t = '0;
    t.d[0] = 32'hDEAD; t.d[1] = 32'hBEEF;
    t.hi_wena = 1'b1; t.lo_wena = 1'b1; t.hi_sel = 2'd1; t.lo_sel = 2'd1;
    step(1'b0, 1'b0, t, "mult");
    chk("mult_hi_bypass", bus.hi_q, 32'hDEAD);
    chk("mult_lo_bypass", bus.lo_q, 32'hBEEF);
    t = '0;
    t.d[10] = 32'hDEAD; t.rf_sel = 3'd4; t.waddr = 5'd3; t.rf_wena = 1'b1;
    step(1'b0, 1'b0, t, "mfhi");
    chk("mfhi_hi_reg", bus.hi_q, 32'hDEAD);
    chk("mfhi_lo_reg", bus.lo_q, 32'hBEEF);
    chk("mfhi_wdata", bus.wb_rf_wdata, 32'hDEAD);

    // mthi held by a three-cycle stall
    mthi = '0;
    mthi.d[8] = 32'h1234; mthi.d[5] = 32'h0A0A; mthi.hi_wena = 1'b1; mthi.hi_sel = 2'd0;
    step(1'b0, 1'b0, mthi, "mthi");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, rand_txn(), "mthi_stall");
      chk("stall_wdata", bus.wb_rf_wdata, 32'h0A0A);
      chk("stall_hi_bypass", bus.hi_q, 32'h1234);
    end
    step(1'b0, 1'b0, '0, "mthi_leave");
    chk("mthi_committed", bus.hi_q, 32'h1234);
    t = '0;
    t.d[8] = 32'h9999; t.hi_wena = 1'b1; t.hi_sel = 2'd3;
    step(1'b0, 1'b0, t, "hi_sel_none");
    chk("hi_sel_none_q", bus.hi_q, 32'h1234);
    step(1'b0, 1'b0, '0, "hi_sel_none_after");
    chk("hi_sel_none_reg", bus.hi_q, 32'h1234);

    // stall and flush together: bubble, and the stalled writer never commits
    mthi.d[8] = 32'h5555;
    mthi.rf_wena = 1'b1; mthi.waddr = 5'd7;
    step(1'b0, 1'b0, mthi, "pre_flush");
    step(1'b1, 1'b1, rand_txn(), "stall_flush");
    chk("flush_valid", 32'(bus.wb_valid), 32'd0);
    chk("flush_wena", 32'(bus.wb_rf_wena), 32'd0);
    chk("flush_hi", bus.hi_q, 32'h1234);
    step(1'b0, 1'b0, '0, "post_flush");
    chk("post_flush_hi", bus.hi_q, 32'h1234);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), rand_txn(), "rand");
    end

    // asynchronous reset with a HI/LO writer in flight
    t = rand_txn();
    t.hi_wena = 1'b1; t.hi_sel = 2'd1; t.d[0] = 32'hCAFE;
    t.lo_wena = 1'b1; t.lo_sel = 2'd2; t.d[3] = 32'hF00D;
    t.rf_wena = 1'b1; t.waddr = 5'd9;
    step(1'b0, 1'b0, t, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    m_lat = '0; m_hi = '0; m_lo = '0;
    chk("arst_valid", 32'(bus.wb_valid), 32'd0);
    chk("arst_wena",  32'(bus.wb_rf_wena), 32'd0);
    chk("arst_waddr", 32'(bus.wb_rf_waddr), 32'd0);
    chk("arst_wdata", bus.wb_rf_wdata, 32'd0);
    chk("arst_hi",    bus.hi_q, 32'd0);
    chk("arst_lo",    bus.lo_q, 32'd0);
    drive('0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0, "post_reset");
    chk("post_reset_hi", bus.hi_q, 32'd0);
    chk("post_reset_lo", bus.lo_q, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
